// File: rtl/atm_keypad_entry_pkg.sv
// Shared encodings for the ATM keypad entry block: FSM states, key codes,
// operation codes and per-field digit limits.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_PIN    = 3'd2,
    ST_OP     = 3'd3,
    ST_AMT    = 3'd4,
    ST_NEWPIN = 3'd5,
    ST_DONE   = 3'd6
  } entry_state_e;

  localparam logic [3:0] KEY_ENTER  = 4'd10;
  localparam logic [3:0] KEY_CLEAR  = 4'd11;
  localparam logic [3:0] KEY_CANCEL = 4'd12;

  localparam logic [2:0] OP_BALANCE    = 3'd3;
  localparam logic [2:0] OP_WITHDRAW   = 3'd4;
  localparam logic [2:0] OP_DEPOSIT    = 3'd5;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

  localparam int         DIGIT_CNT_W   = 4;
  localparam logic [3:0] ACC_DIGITS    = 4'd2;
  localparam logic [3:0] PIN_DIGITS    = 4'd4;
  localparam logic [3:0] OP_DIGITS     = 4'd1;
  localparam logic [3:0] OP_MAX_DIGIT  = 4'd7;
  localparam logic [31:0] ACC_MAX_VALUE = 32'd15;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Keypad-in / command-out bundle between the keypad scanner and the ATM core.
interface atm_keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] new_pin;
  logic [2:0]  operation;
  logic [31:0] amount;
  logic        cmd_valid;
  logic        err;
  logic [2:0]  entry_state;

  modport master (
    output key_valid, key_code,
    input  acc_num, pin, new_pin, operation, amount, cmd_valid, err, entry_state
  );

  modport slave (
    input  key_valid, key_code,
    output acc_num, pin, new_pin, operation, amount, cmd_valid, err, entry_state
  );
endinterface

// File: rtl/atm_keypad_entry_dec_accum.sv
// Decimal digit accumulator (value*10 + digit) with digit count and a full flag;
// one instance is shared by whichever field the entry FSM is currently filling.
module atm_dec_accum
  import atm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic                   push_i,
  input  logic [3:0]             digit_i,
  input  logic [DIGIT_CNT_W-1:0] max_digits_i,
  output logic [31:0]            value_o,
  output logic [31:0]            next_value_o,
  output logic [DIGIT_CNT_W-1:0] count_o,
  output logic                   full_o
);

  logic [31:0]            value_q, value_d;
  logic [DIGIT_CNT_W-1:0] count_q, count_d;

  assign next_value_o = value_q * 32'd10 + {28'd0, digit_i};
  assign full_o       = (count_q >= max_digits_i);
  assign value_o      = value_q;
  assign count_o      = count_q;

  // load starts a fresh field with its first digit in a single cycle
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr_i) begin
      value_d = '0;
      count_d = '0;
    end else if (load_i) begin
      value_d = {28'd0, digit_i};
      count_d = DIGIT_CNT_W'(1);
    end else if (push_i && !full_o) begin
      value_d = next_value_o;
      count_d = count_q + DIGIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// ATM keypad entry FSM: collects account, PIN, operation, amount and new PIN
// from key strobes. Define KEYPAD_TIMEOUT_EN to abandon idle partial entries.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int AMT_MAX_DIGITS = 9
)
(
  input  logic               clk,
  input  logic               rst,
  atm_keypad_entry_if.slave  kp
);

  entry_state_e state_q, state_d;
  logic         err_q, err_d;
  logic [3:0]   acc_q, acc_d;
  logic [15:0]  pin_q, pin_d;
  logic [15:0]  new_pin_q, new_pin_d;
  logic [2:0]   op_q, op_d;
  logic [31:0]  amount_q, amount_d;

  logic                   accum_clr, accum_load, accum_push, accum_full;
  logic [31:0]            accum_value, accum_next;
  logic [DIGIT_CNT_W-1:0] accum_count, max_digits;
  logic                   field_wr;
  logic [31:0]            field_val;
  logic                   key_is_digit;
  logic                   timeout_hit;

  assign key_is_digit = is_digit(kp.key_code);

  atm_dec_accum u_accum (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (accum_clr),
    .load_i       (accum_load),
    .push_i       (accum_push),
    .digit_i      (kp.key_code),
    .max_digits_i (max_digits),
    .value_o      (accum_value),
    .next_value_o (accum_next),
    .count_o      (accum_count),
    .full_o       (accum_full)
  );

  always_comb begin
    case (state_q)
      ST_ACC:    max_digits = ACC_DIGITS;
      ST_PIN:    max_digits = PIN_DIGITS;
      ST_NEWPIN: max_digits = PIN_DIGITS;
      ST_OP:     max_digits = OP_DIGITS;
      ST_AMT:    max_digits = DIGIT_CNT_W'(AMT_MAX_DIGITS);
      default:   max_digits = '0;
    endcase
  end

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            in_entry;

  assign in_entry    = state_q inside {ST_ACC, ST_PIN, ST_OP, ST_AMT, ST_NEWPIN};
  assign timeout_hit = in_entry && !kp.key_valid && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = '0;
    if (in_entry && !kp.key_valid && !timeout_hit)
      to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  // no counter: the comparison is constant-false and only keeps the parameter referenced
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    acc_d      = acc_q;
    pin_d      = pin_q;
    new_pin_d  = new_pin_q;
    op_d       = op_q;
    amount_d   = amount_q;
    accum_clr  = 1'b0;
    accum_load = 1'b0;
    accum_push = 1'b0;
    field_wr   = 1'b0;
    field_val  = '0;

    if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (timeout_hit) begin
      state_d   = ST_IDLE;
      err_d     = 1'b1;
      accum_clr = 1'b1;
      acc_d     = '0;
      pin_d     = '0;
      new_pin_d = '0;
      op_d      = '0;
      amount_d  = '0;
    end else if (kp.key_valid) begin
      if (state_q == ST_IDLE) begin
        if (key_is_digit) begin
          state_d    = ST_ACC;
          accum_load = 1'b1;
          acc_d      = kp.key_code;
          pin_d      = '0;
          new_pin_d  = '0;
          op_d       = '0;
          amount_d   = '0;
        end
      end else if (kp.key_code == KEY_CANCEL) begin
        state_d   = ST_IDLE;
        accum_clr = 1'b1;
      end else if (kp.key_code == KEY_CLEAR) begin
        accum_clr = 1'b1;
        field_wr  = 1'b1;
      end else if (key_is_digit) begin
        if (accum_full || (state_q == ST_OP && kp.key_code > OP_MAX_DIGIT)) begin
          err_d = 1'b1;
        end else begin
          accum_push = 1'b1;
          field_wr   = 1'b1;
          field_val  = accum_next;
        end
      end else if (kp.key_code == KEY_ENTER) begin
        case (state_q)
          ST_ACC: begin
            accum_clr = 1'b1;
            if (accum_value >= 32'd1 && accum_value <= ACC_MAX_VALUE) begin
              state_d = ST_PIN;
            end else begin
              err_d    = 1'b1;
              field_wr = 1'b1;
            end
          end
          ST_PIN, ST_NEWPIN: begin
            if (accum_count == PIN_DIGITS) begin
              accum_clr = 1'b1;
              state_d   = (state_q == ST_PIN) ? ST_OP : ST_DONE;
            end else begin
              err_d = 1'b1;
            end
          end
          ST_OP: begin
            if (accum_count == '0) begin
              err_d = 1'b1;
            end else begin
              accum_clr = 1'b1;
              case (op_q)
                OP_WITHDRAW, OP_DEPOSIT: state_d = ST_AMT;
                OP_CHANGE_PIN:           state_d = ST_NEWPIN;
                OP_BALANCE:              state_d = ST_DONE;
                default:                 state_d = ST_DONE;
              endcase
            end
          end
          ST_AMT: begin
            if (accum_value == '0) begin
              err_d = 1'b1;
            end else begin
              accum_clr = 1'b1;
              state_d   = ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end

    // the field being filled mirrors the accumulator, truncated to its width
    if (field_wr) begin
      case (state_q)
        ST_ACC:    acc_d     = field_val[3:0];
        ST_PIN:    pin_d     = field_val[15:0];
        ST_NEWPIN: new_pin_d = field_val[15:0];
        ST_OP:     op_d      = field_val[2:0];
        ST_AMT:    amount_d  = field_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q     <= 1'b0;
      acc_q     <= '0;
      pin_q     <= '0;
      new_pin_q <= '0;
      op_q      <= '0;
      amount_q  <= '0;
    end else begin
      err_q     <= err_d;
      acc_q     <= acc_d;
      pin_q     <= pin_d;
      new_pin_q <= new_pin_d;
      op_q      <= op_d;
      amount_q  <= amount_d;
    end
  end

  assign kp.acc_num     = acc_q;
  assign kp.pin         = pin_q;
  assign kp.new_pin     = new_pin_q;
  assign kp.operation   = op_q;
  assign kp.amount      = amount_q;
  assign kp.err         = err_q;
  assign kp.cmd_valid   = (state_q == ST_DONE);
  assign kp.entry_state = state_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Table-driven bench for atm_keypad_entry: one vector per clock, expectations
// queued on drive and compared just after the sampling edge.
module tb_atm_keypad_entry;
  import atm_pkg::*;

  localparam int E = 10;
  localparam int C = 11;
  localparam int X = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_keypad_entry_if kp_if ();

  atm_keypad_entry #(
    .TIMEOUT_CYCLES (8),
    .AMT_MAX_DIGITS (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if.slave)
  );

  typedef struct {
    logic        kv;
    logic [3:0]  key;
    logic [2:0]  st;
    logic        err;
    logic        cmd;
    logic        chk;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] npin;
    logic [2:0]  op;
    logic [31:0] amt;
  } vec_t;

  typedef struct {
    int   cyc;
    int   idx;
    vec_t v;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   cyc      = 0;
  int   vec_idx  = 0;
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(int kv, int key, int st, int e, int c, int ck,
                              int acc, int pin, int npin, int op, int amt);
    vec_t v;
    v.kv   = 1'(kv);
    v.key  = 4'(key);
    v.st   = 3'(st);
    v.err  = 1'(e);
    v.cmd  = 1'(c);
    v.chk  = 1'(ck);
    v.acc  = 4'(acc);
    v.pin  = 16'(pin);
    v.npin = 16'(npin);
    v.op   = 3'(op);
    v.amt  = 32'(amt);
    return v;
  endfunction

  function automatic vec_t key_v(int key, int st, int e);
    return mk(1, key, st, e, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t key_f(int key, int st, int e, int c, int acc, int pin, int npin, int op, int amt);
    return mk(1, key, st, e, c, 1, acc, pin, npin, op, amt);
  endfunction

  function automatic vec_t idle_v(int st, int e);
    return mk(0, 0, st, e, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t idle_f(int st, int e, int acc, int pin, int npin, int op, int amt);
    return mk(0, 0, st, e, 0, 1, acc, pin, npin, op, amt);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".state"},     0, 32'(kp_if.entry_state), 32'd0);
    chk({tag, ".err"},       0, 32'(kp_if.err),         32'd0);
    chk({tag, ".cmd_valid"}, 0, 32'(kp_if.cmd_valid),   32'd0);
    chk({tag, ".acc_num"},   0, 32'(kp_if.acc_num),     32'd0);
    chk({tag, ".pin"},       0, 32'(kp_if.pin),         32'd0);
    chk({tag, ".new_pin"},   0, 32'(kp_if.new_pin),     32'd0);
    chk({tag, ".operation"}, 0, 32'(kp_if.operation),   32'd0);
    chk({tag, ".amount"},    0, kp_if.amount,           32'd0);
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    kp_if.key_valid = v.kv;
    kp_if.key_code  = v.key;
    e.cyc = cyc + 1;
    e.idx = vec_idx;
    e.v   = v;
    vec_idx++;
    sb.push_back(e);
  endtask

  task automatic add_keys(input int key, input int n, input int st);
    for (int i = 0; i < n; i++) vecs.push_back(key_v(key, st, 0));
  endtask

  // monitor: compare every expectation due at this edge
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("state",     e.idx, 32'(kp_if.entry_state), 32'(e.v.st));
        chk("err",       e.idx, 32'(kp_if.err),         32'(e.v.err));
        chk("cmd_valid", e.idx, 32'(kp_if.cmd_valid),   32'(e.v.cmd));
        if (e.v.chk) begin
          chk("acc_num",   e.idx, 32'(kp_if.acc_num),   32'(e.v.acc));
          chk("pin",       e.idx, 32'(kp_if.pin),       32'(e.v.pin));
          chk("new_pin",   e.idx, 32'(kp_if.new_pin),   32'(e.v.npin));
          chk("operation", e.idx, 32'(kp_if.operation), 32'(e.v.op));
          chk("amount",    e.idx, kp_if.amount,         e.v.amt);
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    kp_if.key_valid = 1'b0;
    kp_if.key_code  = 4'd0;
    #1 rst = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // keys ignored in IDLE
    vecs.push_back(key_v(13, 0, 0));
    vecs.push_back(key_v(E, 0, 0));
    vecs.push_back(key_v(C, 0, 0));
    vecs.push_back(key_v(X, 0, 0));
    // balance: 1,ENTER,1234,ENTER,3,ENTER
    vecs.push_back(key_f(1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(key_v(E, 2, 0));
    vecs.push_back(key_v(1, 2, 0)); vecs.push_back(key_v(2, 2, 0));
    vecs.push_back(key_v(3, 2, 0)); vecs.push_back(key_v(4, 2, 0));
    vecs.push_back(key_v(E, 3, 0));
    vecs.push_back(key_v(3, 3, 0));
    vecs.push_back(key_f(E, 6, 0, 1, 1, 1234, 0, 3, 0));
    vecs.push_back(idle_f(0, 0, 1, 1234, 0, 3, 0));
    // deposit 1000; a key during DONE is ignored
    vecs.push_back(key_f(2, 1, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(key_v(E, 2, 0));
    vecs.push_back(key_v(2, 2, 0)); vecs.push_back(key_v(3, 2, 0));
    vecs.push_back(key_v(4, 2, 0)); vecs.push_back(key_v(5, 2, 0));
    vecs.push_back(key_v(E, 3, 0));
    vecs.push_back(key_v(5, 3, 0));
    vecs.push_back(key_v(E, 4, 0));
    vecs.push_back(key_f(1, 4, 0, 0, 2, 2345, 0, 5, 1));
    add_keys(0, 3, 4);
    vecs.push_back(key_f(E, 6, 0, 1, 2, 2345, 0, 5, 1000));
    vecs.push_back(key_f(9, 0, 0, 0, 2, 2345, 0, 5, 1000));
    vecs.push_back(idle_v(0, 0));
    // PIN too short, then completed
    vecs.push_back(key_v(3, 1, 0));
    vecs.push_back(key_v(E, 2, 0));
    vecs.push_back(key_v(1, 2, 0)); vecs.push_back(key_v(2, 2, 0)); vecs.push_back(key_v(3, 2, 0));
    vecs.push_back(key_v(E, 2, 1));
    vecs.push_back(key_v(4, 2, 0));
    vecs.push_back(key_f(E, 3, 0, 0, 3, 1234, 0, 0, 0));
    vecs.push_back(key_v(X, 0, 0));
    // fifth PIN digit dropped
    vecs.push_back(key_v(4, 1, 0));
    vecs.push_back(key_v(E, 2, 0));
    vecs.push_back(key_v(9, 2, 0)); vecs.push_back(key_v(8, 2, 0));
    vecs.push_back(key_v(7, 2, 0)); vecs.push_back(key_v(6, 2, 0));
    vecs.push_back(key_f(5, 2, 1, 0, 4, 9876, 0, 0, 0));
    vecs.push_back(key_f(E, 3, 0, 0, 4, 9876, 0, 0, 0));
    vecs.push_back(key_v(X, 0, 0));
    // account out of range, third digit, account zero
    vecs.push_back(key_v(1, 1, 0));
    vecs.push_back(key_v(6, 1, 0));
    vecs.push_back(key_f(E, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(key_v(1, 1, 0));
    vecs.push_back(key_v(2, 1, 0));
    vecs.push_back(key_f(3, 1, 1, 0, 12, 0, 0, 0, 0));
    vecs.push_back(key_v(E, 2, 0));
    vecs.push_back(key_v(X, 0, 0));
    vecs.push_back(key_v(0, 1, 0));
    vecs.push_back(key_f(E, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(key_v(X, 0, 0));
    // CANCEL in AMT
    vecs.push_back(key_v(2, 1, 0));
    vecs.push_back(key_v(E, 2, 0));
    add_keys(7, 4, 2);
    vecs.push_back(key_v(E, 3, 0));
    vecs.push_back(key_v(5, 3, 0));
    vecs.push_back(key_v(E, 4, 0));
    vecs.push_back(key_v(1, 4, 0));
    vecs.push_back(key_v(X, 0, 0));
    vecs.push_back(idle_v(0, 0));
    // change PIN with bad op digits and CLEAR in NEWPIN
    vecs.push_back(key_v(7, 1, 0));
    vecs.push_back(key_v(E, 2, 0));
    add_keys(1, 4, 2);
    vecs.push_back(key_v(E, 3, 0));
    vecs.push_back(key_f(8, 3, 1, 0, 7, 1111, 0, 0, 0));
    vecs.push_back(key_v(6, 3, 0));
    vecs.push_back(key_f(2, 3, 1, 0, 7, 1111, 0, 6, 0));
    vecs.push_back(key_v(E, 5, 0));
    vecs.push_back(key_v(4, 5, 0)); vecs.push_back(key_v(3, 5, 0));
    vecs.push_back(key_f(C, 5, 0, 0, 7, 1111, 0, 6, 0));
    vecs.push_back(key_v(4, 5, 0)); vecs.push_back(key_v(3, 5, 0));
    vecs.push_back(key_v(2, 5, 0)); vecs.push_back(key_v(1, 5, 0));
    vecs.push_back(key_f(E, 6, 0, 1, 7, 1111, 4321, 6, 0));
    vecs.push_back(idle_f(0, 0, 7, 1111, 4321, 6, 0));
    // withdraw: empty op, zero amount, full-length amount
    vecs.push_back(key_v(5, 1, 0));
    vecs.push_back(key_v(E, 2, 0));
    add_keys(0, 4, 2);
    vecs.push_back(key_v(E, 3, 0));
    vecs.push_back(key_v(E, 3, 1));
    vecs.push_back(key_v(4, 3, 0));
    vecs.push_back(key_v(E, 4, 0));
    vecs.push_back(key_v(E, 4, 1));
    vecs.push_back(key_v(0, 4, 0));
    vecs.push_back(key_v(E, 4, 1));
    vecs.push_back(key_f(C, 4, 0, 0, 5, 0, 0, 4, 0));
    add_keys(9, 9, 4);
    vecs.push_back(key_f(1, 4, 1, 0, 5, 0, 0, 4, 999999999));
    vecs.push_back(key_f(E, 6, 0, 1, 5, 0, 0, 4, 999999999));
    vecs.push_back(idle_v(0, 0));
    // op 0 goes straight to DONE
    vecs.push_back(key_v(8, 1, 0));
    vecs.push_back(key_v(E, 2, 0));
    vecs.push_back(key_v(1, 2, 0)); vecs.push_back(key_v(2, 2, 0));
    vecs.push_back(key_v(3, 2, 0)); vecs.push_back(key_v(4, 2, 0));
    vecs.push_back(key_v(E, 3, 0));
    vecs.push_back(key_v(0, 3, 0));
    vecs.push_back(key_f(E, 6, 0, 1, 8, 1234, 0, 0, 0));
    vecs.push_back(idle_v(0, 0));

    foreach (vecs[i]) drive(vecs[i]);

    // reset asserted between edges while in PIN
    drive(key_v(1, 1, 0));
    drive(key_v(E, 2, 0));
    drive(key_f(1, 2, 0, 0, 1, 1, 0, 0, 0));
    drive(key_f(2, 2, 0, 0, 1, 12, 0, 0, 0));
    @(posedge clk);
    #1 kp_if.key_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) drive(idle_f(0, 0, 0, 0, 0, 0, 0));

    // idle cycles in OP
    drive(key_v(1, 1, 0));
    drive(key_v(E, 2, 0));
    drive(key_v(1, 2, 0)); drive(key_v(2, 2, 0));
    drive(key_v(3, 2, 0)); drive(key_v(4, 2, 0));
    drive(key_v(E, 3, 0));
    for (int i = 0; i < 7; i++) drive(idle_v(3, 0));
`ifdef KEYPAD_TIMEOUT_EN
    drive(idle_f(0, 1, 0, 0, 0, 0, 0));
`else
    drive(idle_f(3, 0, 1, 1234, 0, 0, 0));
`endif
    drive(key_v(X, 0, 0));
    @(negedge clk);
    kp_if.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
